// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and constants for the traffic phase scheduler.
package traffic_pkg;

   // Phase codes; 3'd7 is unused and recovers to PH_NSG.
   typedef enum logic [2:0] {
      PH_NSG  = 3'd0,
      PH_NSY  = 3'd1,
      PH_ARN  = 3'd2,
      PH_EWG  = 3'd3,
      PH_EWY  = 3'd4,
      PH_ARE  = 3'd5,
      PH_WALK = 3'd6
   } phase_t;

   // Lamp buses are {red, yellow, green}, one-hot.
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   // Road last served before a WALK phase.
   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor/button inputs and lamp/status outputs of the scheduler.
interface traffic_phase_scheduler_if;
   logic       ns_car;
   logic       ew_car;
   logic       ped_req;
   logic [2:0] nsl;
   logic [2:0] ewl;
   logic       walk;
   logic       ped_ack;
   logic [2:0] phase;

   modport master (
      output ns_car, ew_car, ped_req,
      input  nsl, ewl, walk, ped_ack, phase
   );

   modport slave (
      input  ns_car, ew_car, ped_req,
      output nsl, ewl, walk, ped_ack, phase
   );
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Cycle counter for the current phase: clears on request, saturates at SAT.
module phase_timer #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] SAT   = '1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   // Count up while enabled, hold at SAT, restart from zero on clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i && (count_q != SAT)) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase sequencer for a two-road intersection with a WALK phase.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN = 5,
   parameter int GREEN_MAX = 12,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   traffic_phase_scheduler_if.slave   bus
);

   localparam int TW = $clog2(GREEN_MAX + 1);

   // Last timer value of each phase (a phase of N cycles exits at N-1).
   localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
   localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);
   localparam logic [TW-1:0] T_WALK = TW'(WALK_T - 1);

   phase_t          phase_q, phase_d;
   logic [TW-1:0]   timer;
   logic            ped_pend_q, ped_pend_d;
   logic            last_dir_q, last_dir_d;
   logic [2:0]      nsl_q, ewl_q;
   logic            walk_q, ped_ack_q;
   logic            phase_chg, enter_walk;
   logic            ns_exit, ew_exit;

   // Packs {nsl, ewl} for a phase; everything not explicitly green/yellow is red.
   function automatic logic [5:0] lamps(phase_t p);
      case (p)
         PH_NSG:  lamps = {LAMP_GRN, LAMP_RED};
         PH_NSY:  lamps = {LAMP_YEL, LAMP_RED};
         PH_EWG:  lamps = {LAMP_RED, LAMP_GRN};
         PH_EWY:  lamps = {LAMP_RED, LAMP_YEL};
         default: lamps = {LAMP_RED, LAMP_RED};
      endcase
   endfunction

   phase_timer #(
      .WIDTH (TW),
      .SAT   (T_GMAX)
   ) u_timer (
      .clk_i    (clk),
      .rst_i    (reset),
      .clear_i  (phase_chg),
      .enable_i (1'b1),
      .count_o  (timer)
   );

   // A green yields once its minimum is served and there is conflicting demand,
   // either because its own road went quiet or because the maximum expired.
   assign ns_exit = (timer >= T_GMIN)
                  && (bus.ew_car || ped_pend_q || bus.ped_req)
                  && (!bus.ns_car || (timer == T_GMAX));
   assign ew_exit = (timer >= T_GMIN)
                  && (bus.ns_car || ped_pend_q || bus.ped_req)
                  && (!bus.ew_car || (timer == T_GMAX));

   // Next-phase selection and the road-served memory used to leave WALK.
   always_comb begin
      phase_d    = phase_q;
      last_dir_d = last_dir_q;
      case (phase_q)
         PH_NSG:  if (ns_exit) phase_d = PH_NSY;
         PH_NSY:  if (timer == T_YEL) phase_d = PH_ARN;
         PH_ARN:  if (timer == T_AR) begin
                     phase_d    = ped_pend_q ? PH_WALK : PH_EWG;
                     last_dir_d = DIR_NS;
                  end
         PH_EWG:  if (ew_exit) phase_d = PH_EWY;
         PH_EWY:  if (timer == T_YEL) phase_d = PH_ARE;
         PH_ARE:  if (timer == T_AR) begin
                     phase_d    = ped_pend_q ? PH_WALK : PH_NSG;
                     last_dir_d = DIR_EW;
                  end
         PH_WALK: if (timer == T_WALK) phase_d = (last_dir_q == DIR_NS) ? PH_EWG : PH_NSG;
         default: phase_d = PH_NSG;
      endcase
   end

   assign phase_chg  = (phase_d != phase_q);
   assign enter_walk = (phase_d == PH_WALK) && (phase_q != PH_WALK);
   // A request arriving on the WALK entry cycle is served by that WALK.
   assign ped_pend_d = (ped_pend_q || bus.ped_req) && !enter_walk;

   // Phase register with lamp and acknowledge outputs decoded ahead of the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q    <= PH_NSG;
         ped_pend_q <= 1'b0;
         last_dir_q <= DIR_NS;
         nsl_q      <= LAMP_GRN;
         ewl_q      <= LAMP_RED;
         walk_q     <= 1'b0;
         ped_ack_q  <= 1'b0;
      end else begin
         phase_q        <= phase_d;
         ped_pend_q     <= ped_pend_d;
         last_dir_q     <= last_dir_d;
         {nsl_q, ewl_q} <= lamps(phase_d);
         walk_q         <= (phase_d == PH_WALK);
         ped_ack_q      <= enter_walk;
      end
   end

   assign bus.phase   = phase_q;
   assign bus.nsl     = nsl_q;
   assign bus.ewl     = ewl_q;
   assign bus.walk    = walk_q;
   assign bus.ped_ack = ped_ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: each scenario queues its expected per-cycle phase sequence.
module tb_traffic_phase_scheduler;

   logic clk = 1'b0;
   logic reset;

   traffic_phase_scheduler_if bus ();

   traffic_phase_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] ph;
      logic       ack;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_nsl(input logic [2:0] ph);
      case (ph)
         3'd0:    exp_nsl = 3'b001;
         3'd1:    exp_nsl = 3'b010;
         default: exp_nsl = 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_ewl(input logic [2:0] ph);
      case (ph)
         3'd3:    exp_ewl = 3'b001;
         3'd4:    exp_ewl = 3'b010;
         default: exp_ewl = 3'b100;
      endcase
   endfunction

   // Queue n cycles of phase ph; WALK acknowledges on its first cycle only.
   task automatic push(input int ph, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.ph  = ph[2:0];
         e.ack = (ph == 6) && (i == 0);
         sb.push_back(e);
      end
   endtask

   // Compare the current cycle against the scoreboard, then advance one cycle.
   task automatic run(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("phase",   bus.phase,   e.ph);
            chk("nsl",     bus.nsl,     exp_nsl(e.ph));
            chk("ewl",     bus.ewl,     exp_ewl(e.ph));
            chk("walk",    bus.walk,    (e.ph == 3'd6));
            chk("ped_ack", bus.ped_ack, e.ack);
         end
         chk("safety", (bus.nsl != 3'b100) && (bus.ewl != 3'b100), 1'b0);
         @(negedge clk);
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_phase"}, bus.phase,   3'd0);
      chk({tag, "_nsl"},   bus.nsl,     3'b001);
      chk({tag, "_ewl"},   bus.ewl,     3'b100);
      chk({tag, "_walk"},  bus.walk,    1'b0);
      chk({tag, "_ack"},   bus.ped_ack, 1'b0);
   endtask

   task automatic apply_reset();
      bus.ns_car  = 1'b0;
      bus.ew_car  = 1'b0;
      bus.ped_req = 1'b0;
      reset       = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state("rst");
   endtask

   initial begin
      // Idle: NSG holds with no demand.
      apply_reset();
      reset = 1'b0;
      push(0, 30);
      run(30);

      // EW demand only: NSG min, yellow, all-red, then EWG holds.
      apply_reset();
      bus.ew_car = 1'b1;
      reset      = 1'b0;
      push(0, 5); push(1, 2); push(2, 1); push(3, 10);
      run(18);
      // Swap demand to NS with a button press in EWY, then reset mid-EWY.
      bus.ns_car = 1'b1;
      bus.ew_car = 1'b0;
      push(3, 1); push(4, 1);
      run(1);
      bus.ped_req = 1'b1;
      run(1);
      bus.ped_req = 1'b0;
      #2 reset = 1'b1;
      #1 check_reset_state("async_rst");
      bus.ns_car = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      push(0, 20);
      run(20);

      // Both roads busy: max-green alternation with a 30-cycle period.
      apply_reset();
      bus.ns_car = 1'b1;
      bus.ew_car = 1'b1;
      reset      = 1'b0;
      for (int k = 0; k < 2; k++) begin
         push(0, 12); push(1, 2); push(2, 1);
         push(3, 12); push(4, 2); push(5, 1);
      end
      push(0, 5);
      run(65);

      // Pedestrian pulse in NSG, then another pulse during WALK.
      apply_reset();
      reset = 1'b0;
      push(0, 5); push(1, 2); push(2, 1); push(6, 4);
      push(3, 5); push(4, 2); push(5, 1); push(6, 4);
      push(0, 10);
      run(2);
      bus.ped_req = 1'b1;
      run(1);
      bus.ped_req = 1'b0;
      run(6);
      bus.ped_req = 1'b1;
      run(1);
      bus.ped_req = 1'b0;
      run(24);

      chk("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
